// File: rtl/enc_block_sequencer.sv
// rtl/enc_block_sequencer.sv - assembles key/plaintext words and sequences one 36-bit block at a time through the cipher core
module enc_block_sequencer #(
  parameter int GAP     = 2,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_wr,
  input  logic [8:0]   key_word,
  output logic         key_ready,
  output logic         key_ok,
  input  logic         din_valid,
  input  logic [8:0]   din,
  output logic         din_ready,
  output logic [35:0]  core_S_I,
  output logic [143:0] core_keyin,
  output logic         core_encrypt_en,
  input  logic [35:0]  core_S_j,
  input  logic         core_encr_done,
  output logic [35:0]  dout,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic         err_timeout
);

  localparam int CNT_MAX = (TIMEOUT > GAP) ? TIMEOUT : GAP;
  localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] RUN_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cyc_q, cyc_d;
  logic [3:0]     kcnt_q, kcnt_d;
  logic [134:0]   key_shadow_q, key_shadow_d;
  logic [143:0]   keyin_q, keyin_d;
  logic           key_ok_q, key_ok_d;
  logic [1:0]     wcnt_q, wcnt_d;
  logic [35:0]    stage_q, stage_d;
  logic           staged_full_q, staged_full_d;
  logic [35:0]    s_i_q, s_i_d;
  logic           en_q, en_d;
  logic [35:0]    dout_q, dout_d;
  logic           dout_valid_q, dout_valid_d;
  logic           err_timeout_q, err_timeout_d;
  logic           key_acc;
  logic           din_acc;

  always_comb begin
    state_d       = state_q;
    cyc_d         = cyc_q;
    kcnt_d        = kcnt_q;
    key_shadow_d  = key_shadow_q;
    keyin_d       = keyin_q;
    key_ok_d      = key_ok_q;
    wcnt_d        = wcnt_q;
    stage_d       = stage_q;
    staged_full_d = staged_full_q;
    s_i_d         = s_i_q;
    en_d          = en_q;
    dout_d        = dout_q;
    dout_valid_d  = dout_valid_q;
    err_timeout_d = err_timeout_q;

    key_acc = key_wr && (state_q == ST_IDLE);
    din_acc = din_valid && !staged_full_q;

    // The shadow only holds the first 15 words; the 16th goes straight into the commit.
    if (key_acc) begin
      key_shadow_d = {key_shadow_q[125:0], key_word};
      if (kcnt_q == 4'd15) begin
        keyin_d  = {key_shadow_q, key_word};
        key_ok_d = 1'b1;
        kcnt_d   = 4'd0;
      end else begin
        kcnt_d = kcnt_q + 4'd1;
      end
    end

    if (din_acc) begin
      stage_d = {stage_q[26:0], din};
      if (wcnt_q == 2'd3) begin
        staged_full_d = 1'b1;
        wcnt_d        = 2'd0;
      end else begin
        wcnt_d = wcnt_q + 2'd1;
      end
    end

    if (dout_valid_q && dout_ready) begin
      dout_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        // Registered dout_valid gates the start, so a drain on this edge delays the start by one cycle.
        if (staged_full_q && key_ok_q && !dout_valid_q) begin
          s_i_d         = stage_q;
          staged_full_d = 1'b0;
          en_d          = 1'b1;
          cyc_d         = '0;
          state_d       = ST_RUN;
        end
      end
      ST_RUN: begin
        if (core_encr_done) begin
          dout_d       = core_S_j;
          dout_valid_d = 1'b1;
          en_d         = 1'b0;
          cyc_d        = '0;
          state_d      = ST_GAP;
        end else if (cyc_q == RUN_LAST) begin
          err_timeout_d = 1'b1;
          en_d          = 1'b0;
          cyc_d         = '0;
          state_d       = ST_GAP;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      ST_GAP: begin
        if (cyc_q == GAP_LAST) begin
          cyc_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cyc_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cyc_q         <= '0;
      kcnt_q        <= '0;
      key_shadow_q  <= '0;
      keyin_q       <= '0;
      key_ok_q      <= 1'b0;
      wcnt_q        <= '0;
      stage_q       <= '0;
      staged_full_q <= 1'b0;
      s_i_q         <= '0;
      en_q          <= 1'b0;
      dout_q        <= '0;
      dout_valid_q  <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cyc_q         <= cyc_d;
      kcnt_q        <= kcnt_d;
      key_shadow_q  <= key_shadow_d;
      keyin_q       <= keyin_d;
      key_ok_q      <= key_ok_d;
      wcnt_q        <= wcnt_d;
      stage_q       <= stage_d;
      staged_full_q <= staged_full_d;
      s_i_q         <= s_i_d;
      en_q          <= en_d;
      dout_q        <= dout_d;
      dout_valid_q  <= dout_valid_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign key_ready       = (state_q == ST_IDLE);
  assign key_ok          = key_ok_q;
  assign din_ready       = !staged_full_q;
  assign core_S_I        = s_i_q;
  assign core_keyin      = keyin_q;
  assign core_encrypt_en = en_q;
  assign dout            = dout_q;
  assign dout_valid      = dout_valid_q;
  assign err_timeout     = err_timeout_q;

endmodule
